// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the PWM peripheral.
package pwm_pkg;

   localparam int PWM_BITS = 8;
   localparam int NUM_CH = 16;
   localparam logic [PWM_BITS-1:0] DUTY_FULL = 8'hFF;

   // Prescaler register width; never narrower than one bit, even for CLK_DIV=1.
   function automatic int presc_width(input int clk_div);
      return (clk_div <= 2) ? 1 : $clog2(clk_div);
   endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: prescaler, 8-bit period counter and period-aligned duty shadow.
module pwm_timebase
   import pwm_pkg::*;
#(
   parameter int CLK_DIV = 13
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [PWM_BITS-1:0] pwm_duty_cycle,
   output logic                pwm_raw,
   output logic                wrap
);

   localparam int PW = presc_width(CLK_DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

   logic [PW-1:0]       presc_q, presc_d;
   logic [PWM_BITS-1:0] cnt_q, cnt_d;
   logic [PWM_BITS-1:0] duty_active_q, duty_active_d;
   logic                tick;

   always_comb begin
      tick          = (presc_q == PRESC_LAST);
      presc_d       = tick ? '0 : presc_q + PW'(1);
      cnt_d         = tick ? cnt_q + 8'd1 : cnt_q;
      wrap          = tick && (cnt_q == '1);
      // Duty is only swapped at the period boundary so a period is never cut short.
      duty_active_d = wrap ? pwm_duty_cycle : duty_active_q;
      // Full-scale duty must stay high through count 255 as well.
      pwm_raw       = (duty_active_q == DUTY_FULL) || (cnt_q < duty_active_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q       <= '0;
         cnt_q         <= '0;
         duty_active_q <= '0;
      end else begin
         presc_q       <= presc_d;
         cnt_q         <= cnt_d;
         duty_active_q <= duty_active_d;
      end
   end

endmodule

// File: rtl/pwm_peripheral.sv
// 16-pin PWM peripheral: each pin is off, static high, or the shared PWM waveform.
module pwm_peripheral
   import pwm_pkg::*;
#(
   parameter int CLK_DIV = 13
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] en_reg_out_7_0,
   input  logic [7:0] en_reg_out_15_8,
   input  logic [7:0] en_reg_pwm_7_0,
   input  logic [7:0] en_reg_pwm_15_8,
   input  logic [7:0] pwm_duty_cycle,
   output logic [7:0] out_7_0,
   output logic [7:0] out_15_8,
   output logic       period_start
);

   logic              pwm_raw;
   logic              wrap;
   logic [NUM_CH-1:0] en_out;
   logic [NUM_CH-1:0] en_pwm;
   logic [NUM_CH-1:0] pins_q, pins_d;
   logic              period_start_q, period_start_d;

   pwm_timebase #(
      .CLK_DIV(CLK_DIV)
   ) u_timebase (
      .clk           (clk),
      .rst           (rst),
      .pwm_duty_cycle(pwm_duty_cycle),
      .pwm_raw       (pwm_raw),
      .wrap          (wrap)
   );

   always_comb begin
      en_out         = {en_reg_out_15_8, en_reg_out_7_0};
      en_pwm         = {en_reg_pwm_15_8, en_reg_pwm_7_0};
      // Enabled pins follow the waveform in PWM mode, otherwise sit high.
      pins_d         = en_out & (~en_pwm | {NUM_CH{pwm_raw}});
      period_start_d = wrap;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pins_q         <= '0;
         period_start_q <= 1'b0;
      end else begin
         pins_q         <= pins_d;
         period_start_q <= period_start_d;
      end
   end

   assign out_7_0      = pins_q[7:0];
   assign out_15_8     = pins_q[15:8];
   assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Self-checking bench for pwm_peripheral with CLK_DIV=2 (512-cycle period).
module tb_pwm_peripheral;

   localparam int CLK_DIV = 2;
   localparam int PERIOD  = 256 * CLK_DIV;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] en_reg_out_7_0 = '0, en_reg_out_15_8 = '0;
   logic [7:0] en_reg_pwm_7_0 = '0, en_reg_pwm_15_8 = '0;
   logic [7:0] pwm_duty_cycle = '0;
   logic [7:0] out_7_0, out_15_8;
   logic       period_start;

   int tests = 0;
   int fails = 0;

   pwm_peripheral #(.CLK_DIV(CLK_DIV)) dut (
      .clk            (clk),
      .rst            (rst),
      .en_reg_out_7_0 (en_reg_out_7_0),
      .en_reg_out_15_8(en_reg_out_15_8),
      .en_reg_pwm_7_0 (en_reg_pwm_7_0),
      .en_reg_pwm_15_8(en_reg_pwm_15_8),
      .pwm_duty_cycle (pwm_duty_cycle),
      .out_7_0        (out_7_0),
      .out_15_8       (out_15_8),
      .period_start   (period_start)
   );

   always #5 clk = ~clk;

   // Model: time since reset release determines the counter; duty sampled at each period end.
   int          t;
   logic [7:0]  duty_m;
   logic [15:0] exp_out;
   logic        exp_ps;
   logic        chk_en = 1'b0;
   logic [7:0]  m_cnt;
   logic        m_raw;

   function automatic logic [15:0] model_pins(input logic [15:0] eo, input logic [15:0] ep,
                                              input logic raw);
      logic [15:0] r;
      for (int i = 0; i < 16; i++) r[i] = eo[i] && (ep[i] ? raw : 1'b1);
      return r;
   endfunction

   always_comb begin
      m_cnt = 8'((t / CLK_DIV) % 256);
      m_raw = (duty_m == 8'hFF) ? 1'b1 : (m_cnt < duty_m);
   end

   always @(posedge clk) begin
      if (rst) begin
         t       <= 0;
         duty_m  <= 8'h00;
         exp_out <= '0;
         exp_ps  <= 1'b0;
         chk_en  <= 1'b1;
      end else begin
         exp_out <= model_pins({en_reg_out_15_8, en_reg_out_7_0},
                               {en_reg_pwm_15_8, en_reg_pwm_7_0}, m_raw);
         exp_ps  <= ((t % PERIOD) == PERIOD - 1);
         if ((t % PERIOD) == PERIOD - 1) duty_m <= pwm_duty_cycle;
         t <= t + 1;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         tests++;
         if ({out_15_8, out_7_0, period_start} !== {exp_out, exp_ps}) begin
            fails++;
            $display("FAIL model_cycle t=%0d actual out=%h ps=%b required out=%h ps=%b",
                     t, {out_15_8, out_7_0}, period_start, exp_out, exp_ps);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_ps(output int k);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!period_start && k < 1100);
      chk("period_start_seen", 32'(period_start), 32'd1);
   endtask

   task automatic count2(input int n, input logic [15:0] hi_pat, output int n_hi, output int n_lo);
      n_hi = 0;
      n_lo = 0;
      repeat (n) begin
         @(negedge clk);
         if ({out_15_8, out_7_0} == hi_pat) n_hi++;
         if ({out_15_8, out_7_0} == 16'h0000) n_lo++;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc(3);
      rst = 1'b0;
   endtask

   task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
      {en_reg_out_15_8, en_reg_out_7_0} = eo;
      {en_reg_pwm_15_8, en_reg_pwm_7_0} = ep;
   endtask

   initial begin
      int k, h, l, h2, l2;

      // Reset with random inputs
      set_en(16'($urandom), 16'($urandom));
      pwm_duty_cycle = 8'($urandom);
      rst = 1'b1;
      cyc(1);
      chk("reset_outputs", {15'd0, out_15_8, out_7_0, period_start}, 32'd0);
      cyc(2);
      chk("reset_outputs_late", {15'd0, out_15_8, out_7_0, period_start}, 32'd0);
      rst = 1'b0;
      chk("release_outputs", {15'd0, out_15_8, out_7_0, period_start}, 32'd0);
      wait_ps(k);
      chk("first_ps_latency", 32'(k), 32'd512);

      // Static high on pin 0
      set_en(16'h0001, 16'h0000);
      pwm_duty_cycle = 8'h55;
      cyc(1);
      chk("static_out_7_0", 32'(out_7_0), 32'h01);
      chk("static_out_15_8", 32'(out_15_8), 32'h00);
      count2(1024, 16'h0001, h, l);
      chk("static_hold", 32'(h), 32'd1024);

      // 50% duty: first period runs at duty 0, then 256 high / 256 low
      do_reset();
      set_en(16'hFFFF, 16'hFFFF);
      pwm_duty_cycle = 8'h80;
      wait_ps(k);
      chk("ps_after_reset", 32'(k), 32'd512);
      chk("pwm50_first_period_low", 32'({out_15_8, out_7_0}), 32'h0000);
      cyc(1);
      chk("pwm50_rise", 32'({out_15_8, out_7_0}), 32'hFFFF);
      count2(511, 16'hFFFF, h, l);
      chk("pwm50_high", 32'(h + 1), 32'd256);
      chk("pwm50_low", 32'(l), 32'd256);

      // Extremes
      pwm_duty_cycle = 8'h00;
      wait_ps(k);
      count2(512, 16'hFFFF, h, l);
      chk("duty00_never_high", 32'(l), 32'd512);
      pwm_duty_cycle = 8'hFF;
      wait_ps(k);
      count2(520, 16'hFFFF, h, l);
      chk("dutyFF_no_dip", 32'(h), 32'd520);

      // Mid-period duty write takes effect next period
      pwm_duty_cycle = 8'h40;
      wait_ps(k);
      count2(32, 16'hFFFF, h, l);
      pwm_duty_cycle = 8'hC0;
      count2(480, 16'hFFFF, h2, l2);
      chk("mid_current_high", 32'(h + h2), 32'd128);
      count2(512, 16'hFFFF, h, l);
      chk("mid_next_high", 32'(h), 32'd384);

      // Mixed modes and reset mid-run
      set_en(16'hF00F, 16'h0F0F);
      pwm_duty_cycle = 8'h40;
      wait_ps(k);
      cyc(1);
      chk("mixed_lo_start", 32'(out_7_0), 32'h0F);
      chk("mixed_hi_start", 32'(out_15_8), 32'hF0);
      cyc(169);
      chk("mixed_lo_0x54", 32'(out_7_0), 32'h00);
      chk("mixed_hi_0x54", 32'(out_15_8), 32'hF0);
      rst = 1'b1;
      cyc(1);
      chk("midrun_reset", {15'd0, out_15_8, out_7_0, period_start}, 32'd0);
      rst = 1'b0;
      cyc(1);
      chk("restart_lo", 32'(out_7_0), 32'h00);
      chk("restart_hi", 32'(out_15_8), 32'hF0);
      wait_ps(k);
      chk("restart_ps_latency", 32'(k), 32'd511);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
